// File: rtl/cnt_pkg.sv
// Shared types and elaboration helpers for the BCD modulo counter.
package cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned MAX_DIGITS = 4;
    localparam int unsigned MIN_MODULO = 2;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Packs the low n_digits decimal digits of value as BCD, digit 0 in bits [3:0].
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int unsigned value,
                                                           input int unsigned n_digits);
        logic [4*MAX_DIGITS-1:0] res;
        int unsigned             v;
        res = '0;
        v   = value;
        for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
            if (d < n_digits) begin
                res[4*d +: 4] = 4'(v % 10);
                v             = v / 10;
            end
        end
        return res;
    endfunction

    function automatic bit modulo_legal(input int unsigned n_digits, input int unsigned modulo);
        return (n_digits >= 1) && (n_digits <= MAX_DIGITS) &&
               (modulo >= MIN_MODULO) && (modulo <= pow10(n_digits));
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of next-value logic with ripple carry (up) and borrow (down).
module bcd_digit_cell
    import cnt_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       up_i,
    input  logic       dn_i,
    output bcd_digit_t digit_o,
    output logic       cy_o,
    output logic       bw_o
);

    always_comb begin
        digit_o = digit_i;
        cy_o    = 1'b0;
        bw_o    = 1'b0;
        if (up_i) begin
            if (digit_i >= 4'd9) begin
                digit_o = 4'd0;
                cy_o    = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dn_i) begin
            if (digit_i == 4'd0) begin
                digit_o = 4'd9;
                bw_o    = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cnt_mod_bcd.sv
// N-digit BCD modulo counter with cascade up/down, manual adjust, clear and validated load.
module cnt_mod_bcd
    import cnt_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2,
    parameter int unsigned MODULO   = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CEN,
    input  logic                  DN,
    input  logic                  CLR,
    input  logic                  INC,
    input  logic                  DEC,
    input  logic                  LD,
    input  logic [4*N_DIGITS-1:0] LD_VAL,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  CA,
    output logic                  BO,
    output logic                  LD_ERR
);

    localparam int unsigned W       = 4 * N_DIGITS;
    localparam bit          MOD_OK  = modulo_legal(N_DIGITS, MODULO);
    localparam logic [W-1:0] MAX_BCD = W'(int_to_bcd(MODULO - 1, N_DIGITS));

    if (!MOD_OK) begin : g_bad_modulo
        $error("cnt_mod_bcd: MODULO must lie in 2..10**N_DIGITS with N_DIGITS in 1..4");
    end

    bcd_digit_t   digit_q    [N_DIGITS];
    bcd_digit_t   step_digit [N_DIGITS];
    logic [W-1:0] cur_bcd;
    logic [W-1:0] step_bcd;
    logic [W-1:0] bcd_d;
    logic         ld_err_q;
    logic         ld_err_d;
    logic         do_up;
    logic         do_dn;
    logic         at_max;
    logic         at_zero;
    logic         ld_digits_ok;
    logic         ld_ok;
    logic         top_cy;
    logic         top_bw;

    always_comb begin
        cur_bcd  = '0;
        step_bcd = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            cur_bcd[4*d +: 4]  = digit_q[d];
            step_bcd[4*d +: 4] = step_digit[d];
        end
    end

    assign at_max  = (cur_bcd == MAX_BCD);
    assign at_zero = (cur_bcd == '0);

    // Digits are individually checked, so a plain BCD compare orders values correctly.
    always_comb begin
        ld_digits_ok = 1'b1;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (LD_VAL[4*d +: 4] > 4'd9) begin
                ld_digits_ok = 1'b0;
            end
        end
    end

    assign ld_ok = ld_digits_ok && (LD_VAL <= MAX_BCD);

    // Per-digit ripple chain; each stage is its own variable so the chain is not a comb loop.
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
        logic up_l;
        logic dn_l;
        logic cy_l;
        logic bw_l;
        if (d == 0) begin : g_lsd
            assign up_l = do_up;
            assign dn_l = do_dn;
        end else begin : g_chain
            assign up_l = g_dig[d-1].cy_l;
            assign dn_l = g_dig[d-1].bw_l;
        end
        bcd_digit_cell u_cell (
            .digit_i (digit_q[d]),
            .up_i    (up_l),
            .dn_i    (dn_l),
            .digit_o (step_digit[d]),
            .cy_o    (cy_l),
            .bw_o    (bw_l)
        );
    end

    assign top_cy = g_dig[N_DIGITS-1].cy_l;
    assign top_bw = g_dig[N_DIGITS-1].bw_l;

    // Action decode: only CEN steps may raise carry/borrow to the next stage.
    always_comb begin
        do_up = 1'b0;
        do_dn = 1'b0;
        CA    = 1'b0;
        BO    = 1'b0;
        if (!(rst || CLR || LD)) begin
            if (INC && !DEC) begin
                do_up = 1'b1;
            end else if (DEC && !INC) begin
                do_dn = 1'b1;
            end else if (!INC && !DEC && CEN) begin
                do_up = ~DN;
                do_dn = DN;
                CA    = ~DN & at_max;
                BO    = DN & at_zero;
            end
        end
    end

    always_comb begin
        bcd_d    = cur_bcd;
        ld_err_d = 1'b0;
        if (CLR) begin
            bcd_d = '0;
        end else if (LD) begin
            if (ld_ok) begin
                bcd_d = LD_VAL;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (do_up) begin
            bcd_d = (at_max || top_cy) ? '0 : step_bcd;
        end else if (do_dn) begin
            // Borrow out of the top digit happens exactly when decrementing from zero.
            bcd_d = top_bw ? MAX_BCD : step_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < N_DIGITS; d++) begin
                digit_q[d] <= 4'd0;
            end
            ld_err_q <= 1'b0;
        end else begin
            for (int d = 0; d < N_DIGITS; d++) begin
                digit_q[d] <= bcd_d[4*d +: 4];
            end
            ld_err_q <= ld_err_d;
        end
    end

    assign bcd_out = cur_bcd;
    assign LD_ERR  = ld_err_q;

endmodule

// File: doc/cnt_mod_bcd.md
Name: cnt_mod_bcd

Overview:
- Parametrised N-digit BCD modulo counter; generalises the fixed mod-60 two-digit counter used in the clock/timer datapath.
- Supports up/down cascade counting, manual single-step adjust, synchronous clear, and validated parallel load.
- Provides carry/borrow outputs for chaining stages, for example seconds→minutes→hours with MODULO 60/60/24.

Parameters:
- N_DIGITS, 2, number of BCD digits (1..4).
- MODULO, 60, count range 0..MODULO-1. Legal range is 2..10**N_DIGITS; an elaboration-time assertion fires otherwise.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- CEN  input  1  cascade enable; one step per cycle in direction DN.
- DN  input  1  direction for CEN steps; 0 = up, 1 = down.
- CLR  input  1  synchronous clear to 0.
- INC  input  1  manual step up; generates no carry.
- DEC  input  1  manual step down; generates no borrow.
- LD  input  1  parallel load request.
- LD_VAL  input  4*N_DIGITS  BCD load value; digit 0 in bits [3:0].
- bcd_out  output  4*N_DIGITS  registered BCD count; digit 0 is least significant.
- CA  output  1  combinational carry; high when a CEN up-step wraps MODULO-1→0 this cycle.
- BO  output  1  combinational borrow; high when a CEN down-step wraps 0→MODULO-1 this cycle.
- LD_ERR  output  1  registered one-cycle pulse; flags the previous cycle's LD as rejected.

Behaviour:
- Reset: bcd_out = 0 and LD_ERR = 0. CA and BO are forced to 0 while rst is high.
- Per-cycle priority, highest first:
  - rst
  - CLR
  - LD
  - INC&DEC both high: hold, no step
  - INC
  - DEC
  - CEN
  - otherwise hold
- Only the single highest-priority action takes effect in a cycle.
- Up-step:
  - At MODULO-1, next value is 0.
  - Otherwise BCD increment: a digit at 9 goes to 0 and ripples +1 into the next digit.
- Down-step:
  - At 0, next value is MODULO-1 (BCD constant computed at elaboration).
  - Otherwise BCD decrement: a digit at 0 goes to 9 and ripples -1.
- Carry and borrow:
  - CA = CEN & ~DN & at_max & no higher-priority action. Higher-priority actions are rst, CLR, LD, INC and DEC.
  - BO = CEN & DN & at_zero & no higher-priority action.
  - Manual INC/DEC wraps never assert CA/BO, so time-setting does not disturb downstream stages.
- Load validation:
  - LD is accepted only if every digit of LD_VAL is ≤ 9 and the value is < MODULO.
  - On rejection, bcd_out holds and LD_ERR = 1 in the next cycle.
  - LD_ERR is cleared by rst. It is also cleared in the cycle after CLR, regardless of whether LD was asserted alongside CLR.
- Latency:
  - bcd_out updates one cycle after the action.
  - CA/BO are same-cycle combinational, so a downstream stage samples them with its CEN in the same edge.
- Invariant: bcd_out always holds a valid BCD value < MODULO. No action may produce an illegal digit.
- Reset mid-operation: rst overrides all actions that cycle. The next cycle starts from 0 with no pending LD_ERR.

Decomposition:
- Shared package cnt_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - Function int_to_bcd(value, n_digits) for MAX_BCD = MODULO-1.
  - Localparam checks for the MODULO range.
- Sub-module bcd_digit_cell, one per digit:
  - Combinational next-digit logic with up/down carry-in and carry-out.
  - The top level handles the wrap override against MAX_BCD and the single digit register array.

Test Plan:
- Default params, CEN=1, DN=0 from reset for 60 cycles:
  - bcd_out steps 00,01,…,09,10,…,59,00.
  - CA is high only in the cycle where bcd_out=59.
- DN=1, CEN=1 from 00:
  - Next value 59 and BO high in the 00 cycle.
  - Continues 58 and 57; 10 goes to 09 with the digit borrow correct.
- INC at 59 → 00 with CA=0. DEC at 00 → 59 with BO=0. INC&DEC together at 35 → holds 35.
- Load checks:
  - LD_VAL=8'h42 → bcd_out=42, LD_ERR=0.
  - LD_VAL=8'h60 → holds 42, LD_ERR=1 for exactly one cycle.
  - LD_VAL=8'h3A → rejected, LD_ERR=1.
- Priority:
  - CLR+LD+CEN at 42 → 00, CA=0.
  - rst during CEN at 59 → 00, CA=0, LD_ERR=0.
- N_DIGITS=2, MODULO=24 with CEN=1:
  - Counts 00..23 → 00, CA high at 23.
  - Down from 00 → 23.
- N_DIGITS=3, MODULO=1000: 999 → 000 with CA high.
